// File: rtl/rx_commit_pkg.sv
// rtl/rx_commit_pkg.sv - shared types, defaults and helpers for the rx frame commit buffer
package rx_commit_pkg;

    localparam int DEF_DEPTH    = 2048;
    localparam int DEF_LQ_DEPTH = 16;
    localparam int CNT_W        = 16;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_commit_ram.sv
// rtl/rx_commit_ram.sv - DEPTH x 8 simple dual-port RAM, sync write, sync read (1-cycle latency)
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata valid the cycle after re.
module rx_commit_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_frame_commit.sv
// rtl/rx_frame_commit.sv - store-and-forward buffer releasing only CRC-clean frames downstream
// Ports: clk, rst (async, active-high); in_byte/in_valid/in_ready from eth_rx;
// crc_valid/crc_ok end-of-frame verdict; out_byte/out_valid/out_ready/out_last to the parser;
// frames_ok/frames_bad/frames_ovf saturating frame statistics.
module rx_frame_commit
    import rx_commit_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LQ_DEPTH = DEF_LQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             crc_valid,
    input  logic             crc_ok,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad,
    output logic [CNT_W-1:0] frames_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int LQ_AW = $clog2(LQ_DEPTH);
    localparam int LQC_W = LQ_AW + 1;

    logic [PW-1:0]    wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic [PW-1:0]    cur_len;
    logic             ovf_flag;
    logic [PW-1:0]    lq_mem [LQ_DEPTH];
    logic [LQC_W-1:0] lq_wr, lq_rd, lq_rd_nx, lq_cnt;
    logic             lq_full;
    rd_state_t        state;
    logic [PW-1:0]    rem;
    logic [7:0]       q0, q1;
    logic [1:0]       qcnt;
    logic             rd_pend;
    logic [7:0]       ram_rdata;

    logic             discard, commit, has_space, wr_en, pop, fetch;
    logic [PW-1:0]    wr_base, used;
    logic [2:0]       occ;

    assign lq_cnt   = lq_wr - lq_rd;
    assign lq_rd_nx = lq_rd + 1'b1;
    assign lq_full  = (lq_cnt == LQC_W'(LQ_DEPTH));

    assign discard = crc_valid && (ovf_flag || !crc_ok || (cur_len != '0 && lq_full));
    assign commit  = crc_valid && !ovf_flag && crc_ok && (cur_len != '0) && !lq_full;

    // A byte arriving alongside crc_valid starts the next frame, so space is
    // judged against the write pointer as it stands after the close.
    assign wr_base   = discard ? commit_ptr : wr_ptr;
    assign used      = wr_base - rd_ptr;
    assign has_space = (used != PW'(DEPTH));
    assign wr_en     = in_valid && has_space;

    assign out_valid = (state == R_STREAM) && (qcnt != 2'd0);
    assign out_byte  = q0;
    assign out_last  = out_valid && (rem == PW'(1));
    assign pop       = out_valid && out_ready;

    // Keep at most two bytes (held + in flight) beyond the one being consumed,
    // which hides the RAM latency while never overrunning the q0/q1 skid pair.
    assign occ   = {1'b0, qcnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign fetch = (fetch_ptr != commit_ptr) && (occ <= 3'd1);

    rx_commit_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_base[AW-1:0]),
        .wdata (in_byte),
        .re    (fetch),
        .raddr (fetch_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cur_len    <= '0;
            ovf_flag   <= 1'b0;
            lq_wr      <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_mem[i] <= '0;
            end
            frames_ok  <= '0;
            frames_bad <= '0;
            frames_ovf <= '0;
        end else begin
            in_ready <= 1'b1;
            wr_ptr   <= wr_base + PW'(wr_en);
            cur_len  <= (crc_valid ? '0 : cur_len) + PW'(wr_en);
            ovf_flag <= (ovf_flag && !crc_valid) || (in_valid && !has_space);
            if (commit) begin
                commit_ptr                 <= wr_ptr;
                lq_mem[lq_wr[LQ_AW-1:0]]   <= cur_len;
                lq_wr                      <= lq_wr + 1'b1;
                frames_ok                  <= sat_inc(frames_ok);
            end
            if (crc_valid) begin
                if (ovf_flag) begin
                    frames_ovf <= sat_inc(frames_ovf);
                end else if (!crc_ok) begin
                    frames_bad <= sat_inc(frames_bad);
                end else if (cur_len != '0 && lq_full) begin
                    frames_ovf <= sat_inc(frames_ovf);
                end
            end
        end
    end

    // The head length-queue entry stays occupied while its frame streams and is
    // retired on the frame's last beat, when the next length is taken directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= R_IDLE;
            rem       <= '0;
            lq_rd     <= '0;
            rd_ptr    <= '0;
            fetch_ptr <= '0;
            rd_pend   <= 1'b0;
            qcnt      <= 2'd0;
            q0        <= 8'h00;
            q1        <= 8'h00;
        end else begin
            rd_pend <= fetch;
            if (fetch) begin
                fetch_ptr <= fetch_ptr + 1'b1;
            end

            qcnt <= qcnt + {1'b0, rd_pend} - {1'b0, pop};
            if (pop) begin
                if (qcnt == 2'd2) begin
                    q0 <= q1;
                    if (rd_pend) q1 <= ram_rdata;
                end else if (rd_pend) begin
                    q0 <= ram_rdata;
                end
            end else if (rd_pend) begin
                if (qcnt == 2'd0) q0 <= ram_rdata;
                else              q1 <= ram_rdata;
            end

            case (state)
                R_IDLE: begin
                    if (lq_cnt != '0) begin
                        rem   <= lq_mem[lq_rd[LQ_AW-1:0]];
                        state <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rem    <= rem - 1'b1;
                        if (rem == PW'(1)) begin
                            lq_rd <= lq_rd_nx;
                            if (lq_cnt > LQC_W'(1)) begin
                                rem <= lq_mem[lq_rd_nx[LQ_AW-1:0]];
                            end else begin
                                state <= R_IDLE;
                            end
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_commit.sv
// tb/tb_rx_frame_commit.sv - directed self-checking bench for rx_frame_commit
module tb_rx_frame_commit;

    localparam int DEPTH    = 16;
    localparam int LQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        crc_valid = 1'b0;
    logic        crc_ok = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [15:0] frames_ok, frames_bad, frames_ovf;

    always #5 clk = ~clk;

    rx_frame_commit #(.DEPTH(DEPTH), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .crc_valid  (crc_valid),
        .crc_ok     (crc_ok),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad),
        .frames_ovf (frames_ovf)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic       prev_l = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_byte !== prev_b || out_last !== prev_l))
                stall_err <= stall_err + 1;
            if (out_valid && out_ready)
                got_q.push_back({out_last, out_byte});
            prev_stall <= out_valid && !out_ready;
            prev_b     <= out_byte;
            prev_l     <= out_last;
        end
    end

    logic rnd_mode = 1'b0;
    logic rdy_set = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_set;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic close(input logic ok);
        crc_valid = 1'b1;
        crc_ok    = ok;
        tick();
        crc_valid = 1'b0;
        crc_ok    = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] data, input int n, input logic ok);
        for (int j = 0; j < n; j++) put_byte(data[8*(n-1-j) +: 8]);
        close(ok);
    endtask

    task automatic expect_frame(input logic [63:0] data, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), data[8*(n-1-j) +: 8]});
    endtask

    task automatic wait_drain();
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin
            tick();
            t++;
        end
    endtask

    task automatic drain_compare(input string tag);
        int n;
        wait_drain();
        repeat (5) tick();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        crc_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int lat;
        logic [63:0] data;
        int n;

        // reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_counters", {frames_ok, frames_bad | frames_ovf}, 0);
        rst = 1'b0;
        tick();
        check("in_ready_up", in_ready, 1);

        // good frame + commit latency + empty close
        rdy_set = 1'b1;
        tick();
        tick();
        send_frame(64'h00_03_41_42_43, 5, 1'b1);
        check("good_frames_ok", frames_ok, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("commit_latency", lat, 3);
        expect_frame(64'h00_03_41_42_43, 5);
        drain_compare("good");
        close(1'b1);
        check("empty_frames_ok", frames_ok, 1);
        check("empty_frames_bad", frames_bad, 0);

        // bad then good
        do_reset();
        send_frame(64'h00_01_58, 3, 1'b0);
        send_frame(64'h00_01_41, 3, 1'b1);
        expect_frame(64'h00_01_41, 3);
        drain_compare("badgood");
        check("badgood_bad", frames_bad, 1);
        check("badgood_ok", frames_ok, 1);
        check("badgood_ovf", frames_ovf, 0);

        // close coinciding with the first byte of the next frame
        do_reset();
        put_byte(8'h11);
        put_byte(8'h22);
        in_byte = 8'h33; in_valid = 1'b1; crc_valid = 1'b1; crc_ok = 1'b1;
        tick();
        in_valid = 1'b0; crc_valid = 1'b0; crc_ok = 1'b0;
        put_byte(8'h44);
        close(1'b1);
        expect_frame(64'h11_22, 2);
        expect_frame(64'h33_44, 2);
        drain_compare("overlap");
        check("overlap_ok", frames_ok, 2);

        // byte buffer overflow
        rdy_set = 1'b0;
        do_reset();
        for (int j = 0; j < 20; j++) put_byte(8'(j + 1));
        close(1'b1);
        repeat (10) tick();
        check("bovf_no_output", got_q.size(), 0);
        check("bovf_ovf", frames_ovf, 1);
        check("bovf_ok", frames_ok, 0);
        send_frame(64'h00_02_41_42, 4, 1'b1);
        rdy_set = 1'b1;
        expect_frame(64'h00_02_41_42, 4);
        drain_compare("bovf_after");
        check("bovf_after_ok", frames_ok, 1);

        // length queue overflow
        rdy_set = 1'b0;
        do_reset();
        send_frame(64'h01_02_03, 3, 1'b1);
        send_frame(64'h04_05_06, 3, 1'b1);
        send_frame(64'h07_08_09, 3, 1'b1);
        check("qovf_ovf", frames_ovf, 1);
        check("qovf_ok", frames_ok, 2);
        repeat (5) tick();
        check("qovf_held", got_q.size(), 0);
        rdy_set = 1'b1;
        expect_frame(64'h01_02_03, 3);
        expect_frame(64'h04_05_06, 3);
        drain_compare("qovf");

        // random backpressure over 10 frames
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n = 1 + (i % 5);
            data = '0;
            for (int j = 0; j < n; j++) data = {data[55:0], 8'(i * 16 + j)};
            send_frame(data, n, 1'b1);
            expect_frame(data, n);
            wait_drain();
        end
        drain_compare("rand");
        check("rand_ok", frames_ok, 10);
        rnd_mode = 1'b0;
        rdy_set  = 1'b1;

        // reset mid-stream
        do_reset();
        for (int j = 0; j < 10; j++) put_byte(8'hA0 + 8'(j));
        close(1'b1);
        lat = 0;
        while (got_q.size() < 3 && lat < 50) begin
            tick();
            lat++;
        end
        check("mid_streaming", (got_q.size() >= 3), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_byte", out_byte, 0);
        check("mid_rst_ok", frames_ok, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        got_q.delete();
        exp_q.delete();
        send_frame(64'h00_02_41_42, 4, 1'b1);
        expect_frame(64'h00_02_41_42, 4);
        drain_compare("after_rst");
        check("after_rst_ok", frames_ok, 1);

        check("stall_stable", stall_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
